// File: rtl/seg_scan_pkg.sv
// Shared types, segment constants and the hex-to-7-segment decode for seg_scan_mux.
// Combinational helpers only; no latency, no flow control.
package seg_scan_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] hex_digit_t;

    localparam seg_t SEG_BLANK = 7'h00;
    localparam seg_t SEG_ZERO  = 7'h3F;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    function automatic seg_t hex_to_seg(input hex_digit_t d);
        seg_t s;
        case (d)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Display bus: load-side data/strobe in, anode/segment pins and frame pulse out.
// Pure wiring; load is a single-cycle write strobe with no backpressure.
interface seg_scan_mux_if #(
    parameter int WIDTH = 4
);
    import seg_scan_pkg::*;

    logic [4*WIDTH-1:0] data_in;
    logic [WIDTH-1:0]   dp_in;
    logic               load;
    logic [WIDTH-1:0]   an;
    seg_t               seg;
    logic               dp;
    logic               frame_done;

    modport master (
        output data_in, dp_in, load,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  data_in, dp_in, load,
        output an, seg, dp, frame_done
    );

endinterface

// File: rtl/seg_scan_mux_prescaler.sv
// scan_prescaler: free-running 0..PRESCALE-1 counter, tick on the terminal count.
// tick is combinational from the count register; no backpressure, never stalls.
module scan_prescaler #(
    parameter int PRESCALE = 1000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: double-buffered multiplexed 7-segment driver; SEG_SCAN_BLANK_EN adds leading-zero blanking.
// All outputs registered, anode and pattern update on the same edge; load never stalls (last load per frame wins).
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1000
) (
    input  logic           clk,
    input  logic           reset_n,
    seg_scan_mux_if.slave  bus
);

`ifdef SEG_SCAN_BLANK_EN
    localparam seg_t SEG_RST = SEG_BLANK;
`else
    localparam seg_t SEG_RST = SEG_ZERO;
`endif
    localparam logic [WIDTH-1:0] AN_RST = {1'b1, {(WIDTH-1){1'b0}}};

    logic                tick;
    logic                wrap;
    logic [WIDTH-1:0]    an_q, an_nxt;
    logic [4*WIDTH-1:0]  pend_dat, act_dat, act_nxt;
    logic [WIDTH-1:0]    pend_dp, act_dp, act_dp_nxt;
    hex_digit_t          lit_dig;
    logic                lit_dp;
    logic                blank_lit;
    seg_t                seg_q, seg_nxt;
    logic                dp_q;
    logic                fd_q;

    scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    assign wrap = tick & an_q[0];

    // Pattern is decoded from next-state anode/buffer so it lands with the anode.
    always_comb begin
        an_nxt     = tick ? {an_q[0], an_q[WIDTH-1:1]} : an_q;
        act_nxt    = wrap ? pend_dat : act_dat;
        act_dp_nxt = wrap ? pend_dp  : act_dp;
        lit_dig    = '0;
        lit_dp     = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (an_nxt[i]) begin
                lit_dig = lit_dig | act_nxt[4*i +: 4];
                lit_dp  = lit_dp  | act_dp_nxt[i];
            end
        end
    end

`ifdef SEG_SCAN_BLANK_EN
    logic [WIDTH-1:0] blank_mask;
    logic             lead_zero;

    always_comb begin
        blank_mask = '0;
        lead_zero  = 1'b1;
        for (int i = WIDTH - 1; i > 0; i--) begin
            lead_zero     = lead_zero & (act_nxt[4*i +: 4] == 4'h0);
            blank_mask[i] = lead_zero;
        end
    end

    assign blank_lit = |(blank_mask & an_nxt);
`else
    assign blank_lit = 1'b0;
`endif

    assign seg_nxt = blank_lit ? SEG_BLANK : hex_to_seg(lit_dig);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_dat <= '0;
            pend_dp  <= '0;
            act_dat  <= '0;
            act_dp   <= '0;
            an_q     <= AN_RST;
            seg_q    <= SEG_RST;
            dp_q     <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            if (bus.load) begin
                pend_dat <= bus.data_in;
                pend_dp  <= bus.dp_in;
            end
            act_dat  <= act_nxt;
            act_dp   <= act_dp_nxt;
            an_q     <= an_nxt;
            seg_q    <= seg_nxt;
            dp_q     <= lit_dp;
            fd_q     <= wrap;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = fd_q;

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Time-multiplexed 7-segment display driver. It holds a WIDTH-digit hexadecimal value and rotates a one-hot digit enable across the digits at a programmable rate, presenting the matching segment pattern for each digit. Display data is double-buffered, so a frame is never torn. The block sits directly downstream of the one-hot ring sequencing in the display path and drives the board's anode and segment pins.

## Interface
- WIDTH, 4, number of digits (≥2)
- PRESCALE, 1000, clk cycles each digit stays lit (≥1)

- clk  input  1  rising-edge clock
- reset_n  input  1  reset; synchronous, active-low
- data_in  input  4*WIDTH  hex digits; digit i = data_in[4i+3:4i]
- dp_in  input  WIDTH  decimal point per digit
- load  input  1  capture data_in/dp_in into the pending buffer
- an  output  WIDTH  one-hot digit enable, active-high
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high
- dp  output  1  decimal point of the lit digit
- frame_done  output  1  one-cycle pulse at each frame wrap

## Operation
- Prescaler
  - Counts 0..PRESCALE-1.
  - tick is asserted when count == PRESCALE-1; the count then returns to 0.
  - PRESCALE=1 gives tick every cycle.
- Digit rotator
  - an is one-hot and resets to 1<<(WIDTH-1).
  - On tick it shifts right by one. an[0] wraps to an[WIDTH-1].
  - Outside reset, an is never zero and never multi-hot.
- Wrap
  - wrap = tick while an[0] is set.
  - On wrap: frame_done=1 for one cycle, and the active buffer loads from the pending buffer.
- Buffers
  - load=1 writes data_in/dp_in into pending in that cycle.
  - Active only changes at a wrap.
  - If load and wrap occur in the same cycle, active takes the old pending value; the new data appears one frame later.
  - Multiple loads within a frame: the last one wins.
- Decode
  - Hex 0..F → 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
  - dp = active dp bit of the lit digit.
- Reset
  - reset_n=0 has priority over load and tick. Pending, active, count, and frame_done all clear.
  - an = 1<<(WIDTH-1).
  - seg = 7'h3F, or 7'h00 with blanking compiled in.
  - dp = 0.
  - A reset mid-frame discards any pending load.

## Timing
- seg, dp, an, and frame_done are all registered.
- seg/dp change on the same clock edge as an. There is no cycle of skew between anode and pattern.
- Each digit is lit for exactly PRESCALE cycles. A frame is WIDTH*PRESCALE cycles.
- The first tick after reset is PRESCALE cycles after reset_n rises.
- Load-to-display latency is at most (WIDTH*PRESCALE)+1 cycles. Data appears on the edge after the first wrap that follows the load cycle.
- frame_done rises on the edge where an returns to 1<<(WIDTH-1).

## Configuration
- SEG_SCAN_BLANK_EN enables leading-zero blanking.
- Defined:
  - A digit at index i>0 outputs seg=7'h00 when it and all higher active digits are 0.
  - dp still follows dp_in.
  - Digit 0 is never blanked.
  - an keeps rotating.
- Undefined: every digit is decoded, including zeros.
- The blanking mask is computed from the active buffer and registered alongside seg.

## Structure
- seg_scan_pkg holds:
  - seg_t (logic [6:0]).
  - hex_digit_t (logic [3:0]).
  - Function hex_to_seg implementing the decode table.
  - Constants SEG_BLANK = 7'h00 and SEG_ZERO = 7'h3F.
- Sub-module scan_prescaler(PRESCALE): clk, reset_n, tick output. Counter width is max(1, $clog2(PRESCALE)).
- The top level holds the rotator, the buffers, the decode register, and the blanking logic.

## Test plan
- Reset, WIDTH=4, PRESCALE=4, no load → an=4'b1000, seg=3F, dp=0, frame_done=0. an steps 1000→0100→0010→0001→1000 every 4 cycles, and frame_done pulses once per 16 cycles.
- load data_in=16'h12AF, dp_in=4'b0010 mid-frame → after the next wrap, successive digits show seg 06,5B,77,71, with dp=1 only while an=0010.
- load asserted on the exact wrap cycle with 16'h8888 → the current frame still shows the prior pending value, and 7F appears on all digits one frame later.
- reset_n=0 for one cycle mid-frame after a pending load of 16'h5555 → an=1000, count=0, and the display stays at 0. The pending data never appears.
- PRESCALE=1 → an rotates every cycle and frame_done pulses every WIDTH cycles. an remains one-hot throughout (bench assertion).
- With SEG_SCAN_BLANK_EN, data 16'h0070 → digits 3,2 show 00, digit 1 shows 07, digit 0 shows 3F. Data 16'h0000 → only digit 0 shows 3F.
